// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one bit-serial slave bus between NM masters,
// with a hold timeout and a one-cycle idle gap between bus owners.
module serial_bus_arbiter #(
  parameter int NM       = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NM-1:0] breq,
  input  logic [NM-1:0] m_valid,
  input  logic [NM-1:0] m_wren,
  input  logic [NM-1:0] m_addr,
  input  logic [NM-1:0] m_data,
  output logic [NM-1:0] bgrant,
  output logic [1:0]    owner,
  output logic          busy,
  output logic          timeout,
  output logic          bus_valid,
  output logic          bus_wren,
  output logic          bus_addr,
  output logic          bus_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [2:0] NM3       = 3'(NM);

  state_t          state_q, state_d;
  logic [NM-1:0]   bgrant_q, bgrant_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;

  logic            found;
  logic [1:0]      winner;
  logic [2:0]      scan;
  logic            owner_req;
  logic            sel_valid, sel_wren, sel_addr, sel_data;
  logic [1:0]      next_ptr;

  // Scan rr_ptr, rr_ptr+1, ... modulo NM; first requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      scan = {1'b0, rr_ptr_q} + 3'(k);
      if (scan >= NM3) scan = scan - NM3;
      for (int unsigned i = 0; i < NM; i++) begin
        if (!found && scan == 3'(i) && breq[i]) begin
          found  = 1'b1;
          winner = 2'(i);
        end
      end
    end
  end

  always_comb begin
    owner_req = 1'b0;
    sel_valid = 1'b0;
    sel_wren  = 1'b0;
    sel_addr  = 1'b0;
    sel_data  = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (owner_q == 2'(i)) begin
        owner_req = breq[i];
        sel_valid = m_valid[i];
        sel_wren  = m_wren[i];
        sel_addr  = m_addr[i];
        sel_data  = m_data[i];
      end
    end
  end

  assign next_ptr = (owner_q == 2'(NM - 1)) ? 2'd0 : owner_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    bgrant_d   = bgrant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE, TURN: begin
        if (found) begin
          state_d    = GRANT;
          owner_d    = winner;
          hold_cnt_d = '0;
          for (int unsigned i = 0; i < NM; i++) bgrant_d[i] = (winner == 2'(i));
        end else begin
          state_d  = IDLE;
          bgrant_d = '0;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        // Release has priority over any new request; re-arbitration happens in TURN.
        if (!owner_req || hold_cnt_q == HOLD_LAST) begin
          state_d   = TURN;
          bgrant_d  = '0;
          rr_ptr_d  = next_ptr;
          timeout_d = owner_req;
        end
      end
      default: begin
        state_d  = IDLE;
        bgrant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bgrant_q   <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bgrant_q   <= bgrant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bgrant    = bgrant_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q == GRANT);
  assign bus_valid = busy & sel_valid;
  assign bus_wren  = busy & sel_wren;
  assign bus_addr  = busy & sel_addr;
  assign bus_data  = busy & sel_data;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed and randomized bench for serial_bus_arbiter, checked against a
// tenure-level reference model of the arbitration rules.
module tb_serial_bus_arbiter;

  localparam int NM       = 2;
  localparam int MAX_HOLD = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] breq, m_valid, m_wren, m_addr, m_data;
  logic [NM-1:0] bgrant;
  logic [1:0]    owner;
  logic          busy, timeout, bus_valid, bus_wren, bus_addr, bus_data;

  serial_bus_arbiter #(.NM(NM), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .breq(breq),
    .m_valid(m_valid), .m_wren(m_wren), .m_addr(m_addr), .m_data(m_data),
    .bgrant(bgrant), .owner(owner), .busy(busy), .timeout(timeout),
    .bus_valid(bus_valid), .bus_wren(bus_wren), .bus_addr(bus_addr), .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a tenure is either running (with an owner and age) or not.
  bit mdl_tenure;
  int mdl_owner;
  int mdl_age;
  int mdl_next_first;
  bit mdl_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      mdl_tenure = 0; mdl_owner = 0; mdl_age = 0; mdl_next_first = 0; mdl_timeout = 0;
    end else if (mdl_tenure) begin
      mdl_timeout = 0;
      if (!breq[mdl_owner] || mdl_age == MAX_HOLD - 1) begin
        mdl_timeout    = breq[mdl_owner];
        mdl_tenure     = 0;
        mdl_next_first = (mdl_owner + 1) % NM;
      end else begin
        mdl_age++;
      end
    end else begin
      mdl_timeout = 0;
      for (int k = 0; k < NM; k++) begin
        int idx;
        idx = (mdl_next_first + k) % NM;
        if (!mdl_tenure && breq[idx]) begin
          mdl_tenure = 1; mdl_owner = idx; mdl_age = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [NM-1:0] g;
    g = '0;
    if (mdl_tenure) g[mdl_owner] = 1'b1;
    chk("bgrant",    32'(bgrant),   32'(g));
    chk("owner",     32'(owner),    32'(mdl_owner));
    chk("busy",      32'(busy),     32'(mdl_tenure));
    chk("timeout",   32'(timeout),  32'(mdl_timeout));
    chk("bus_valid", 32'(bus_valid), mdl_tenure ? 32'(m_valid[mdl_owner]) : 32'd0);
    chk("bus_wren",  32'(bus_wren),  mdl_tenure ? 32'(m_wren[mdl_owner])  : 32'd0);
    chk("bus_addr",  32'(bus_addr),  mdl_tenure ? 32'(m_addr[mdl_owner])  : 32'd0);
    chk("bus_data",  32'(bus_data),  mdl_tenure ? 32'(m_data[mdl_owner])  : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    logic [11:0] addr_pat;
    int cnt;
    int toggle_div;
    addr_pat = 12'hA5C;

    // Reset with everything asserted
    rst = 1'b1; breq = '1; m_valid = '1; m_wren = '1; m_addr = '1; m_data = '1;
    cycle(); cycle();
    chk("rst_bgrant", 32'(bgrant), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_bus",    32'({bus_valid, bus_wren, bus_addr, bus_data}), 32'd0);
    rst = 1'b0; breq = '0; m_valid = '0; m_wren = '0; m_addr = '0; m_data = '0;
    cycle();

    // Single master, serial address tracks bit for bit
    breq = 2'b01; cycle();
    chk("single_grant", 32'(bgrant), 32'd1);
    chk("single_busy",  32'(busy),   32'd1);
    for (int i = 11; i >= 0; i--) begin
      m_addr[0] = addr_pat[i];
      m_addr[1] = ~addr_pat[i];
      #1 chk("addr_bit", 32'(bus_addr), 32'(addr_pat[i]));
      cycle();
    end
    m_valid = '1; m_addr = '1; m_data = '1;
    breq = 2'b00; cycle();
    chk("single_rel", 32'(bgrant), 32'd0);
    chk("turn_bus",   32'({bus_valid, bus_wren, bus_addr, bus_data}), 32'd0);
    cycle();
    chk("idle_busy", 32'(busy), 32'd0);

    // Round robin 0,1,0
    rst = 1'b1; cycle(); rst = 1'b0;
    breq = 2'b11; cycle();
    chk("rr_first", 32'(bgrant), 32'b01);
    cycle(); cycle();
    breq = 2'b10; cycle();
    chk("rr_gap", 32'(bgrant), 32'b00);
    cycle();
    chk("rr_second", 32'(bgrant), 32'b10);
    breq = 2'b11; cycle(); cycle();
    breq = 2'b01; cycle();
    chk("rr_gap2", 32'(bgrant), 32'b00);
    cycle();
    chk("rr_third", 32'(bgrant), 32'b01);
    breq = 2'b00; cycle(); cycle();

    // Timeout: master 1 holds while master 0 waits
    breq = 2'b10; cycle();
    chk("to_grant", 32'(bgrant), 32'b10);
    breq = 2'b11;
    cnt = 1;
    while (bgrant == 2'b10 && cnt < 200) begin
      cycle();
      if (bgrant == 2'b10) cnt++;
    end
    chk("to_len",   32'(cnt),     32'd64);
    chk("to_pulse", 32'(timeout), 32'd1);
    cycle();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_next",      32'(bgrant),  32'b01);
    breq = 2'b00; cycle(); cycle();

    // Reset mid-tenure; pointer currently favours master 1
    breq = 2'b01; cycle();
    chk("mid_grant", 32'(bgrant), 32'b01);
    for (int i = 0; i < 4; i++) begin
      m_valid = 2'($urandom); m_data = 2'($urandom); m_addr = 2'($urandom);
      cycle();
    end
    rst = 1'b1; cycle();
    chk("mid_rst_grant", 32'(bgrant), 32'd0);
    chk("mid_rst_bus",   32'({bus_valid, bus_wren, bus_addr, bus_data}), 32'd0);
    rst = 1'b0; breq = 2'b11; cycle();
    chk("mid_restart", 32'(bgrant), 32'b01);

    // Isolation: master 1 lines and request toggle every cycle
    for (int i = 0; i < 20; i++) begin
      breq[1]    = ~breq[1];
      m_valid[1] = ~m_valid[1];
      m_data[1]  = ~m_data[1];
      m_data[0]  = 1'($urandom);
      m_valid[0] = 1'($urandom);
      cycle();
      chk("iso_grant", 32'(bgrant), 32'b01);
    end
    breq = 2'b00; cycle();
    chk("iso_rel", 32'(bgrant), 32'b00);

    // Random traffic: short requests first, then long holds that hit the timeout
    for (int n = 0; n < 3000; n++) begin
      toggle_div = (n < 1500) ? 8 : 120;
      for (int m = 0; m < NM; m++)
        if ($urandom_range(toggle_div - 1) == 0) breq[m] = ~breq[m];
      m_valid = NM'($urandom); m_wren = NM'($urandom);
      m_addr  = NM'($urandom); m_data = NM'($urandom);
      rst = ($urandom_range(299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
